// File: rtl/ipsxe_floating_point_fma_normalizer_v1_0_pkg.sv
// Shared floating-point helpers: bias and internal widths derived from the packed format.
// Functions serve parameterised modules; localparams describe the default single-precision format.
package ipsxe_floating_point_fma_normalizer_v1_0_pkg;

    localparam int DEF_EXP_WIDTH = 8;
    localparam int DEF_MAN_WIDTH = 23;

    function automatic int fp_bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    function automatic int fp_mag_width(input int man_width);
        return 2 * (man_width + 1) + 1;
    endfunction

    function automatic int fp_iexp_width(input int exp_width);
        return exp_width + 3;
    endfunction

    localparam int BIAS       = fp_bias(DEF_EXP_WIDTH);
    localparam int MAG_WIDTH  = fp_mag_width(DEF_MAN_WIDTH);
    localparam int IEXP_WIDTH = fp_iexp_width(DEF_EXP_WIDTH);

endpackage

// File: rtl/ipsxe_floating_point_lzc_v1_0.sv
// Leading-one detector: index of the most significant set bit plus an all-zero flag.
// Purely combinational, no flow control.
module ipsxe_floating_point_lzc_v1_0 #(
    parameter int WIDTH = 49,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             zero
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        index = '0;
        zero  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                index = IDX_W'(i);
                zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_register_v1_0.sv
// Optional pipeline register with clock enable; latency 1 when ENABLE, else a wire.
// No backpressure: ce low simply holds the stored word.
module ipsxe_floating_point_register_v1_0 #(
    parameter int WIDTH  = 1,
    parameter bit ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (ENABLE) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (ce) begin
                    q <= d;
                end
            end
        end else begin : g_wire
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/ipsxe_floating_point_fma_normalizer_v1_0.sv
// FMA normaliser: leading-one detect, align, round-to-nearest-even and pack to IEEE-754.
// Latency LATENCY_CONFIG enabled cycles (0..3); throughput 1/cycle, i_aclken low freezes all stages.
module ipsxe_floating_point_fma_normalizer_v1_0
    import ipsxe_floating_point_fma_normalizer_v1_0_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MAN_WIDTH      = 23,
    parameter int LATENCY_CONFIG = 3,
    parameter int W_USER         = 1
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst_n,
    input  logic                                                  i_aclken,
    input  logic                                                  i_valid,
    input  logic [(2*(MAN_WIDTH+1)+1)+(EXP_WIDTH+1)+1-1:0]        i_add_out,
    input  logic [W_USER-1:0]                                     i_user,
    output logic                                                  o_valid,
    output logic [EXP_WIDTH+MAN_WIDTH:0]                          o_result,
    output logic [W_USER-1:0]                                     o_user
);

    localparam int EXP_BIAS = fp_bias(EXP_WIDTH);
    localparam int MAG_W    = fp_mag_width(MAN_WIDTH);
    localparam int IEXP_W   = fp_iexp_width(EXP_WIDTH);
    localparam int IDX_W    = $clog2(MAG_W);
    localparam int RES_W    = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int IN_W     = MAG_W + EXP_WIDTH + 2;

    localparam logic signed [IEXP_W-1:0] EXP_INF  = IEXP_W'((1 << EXP_WIDTH) - 1);
    localparam logic signed [IEXP_W-1:0] EXP_ZERO = '0;

    typedef struct packed {
        logic              vld;
        logic [W_USER-1:0] user;
        logic              sign;
        logic [EXP_WIDTH:0] exp_sum;
        logic [MAG_W-1:0]  mag;
        logic [IDX_W-1:0]  lead;
        logic              zero;
    } s1_t;

    typedef struct packed {
        logic              vld;
        logic [W_USER-1:0] user;
        logic              sign;
        logic [MAG_W-1:0]  aligned;
        logic [IEXP_W-1:0] exp;
        logic              zero;
    } s2_t;

    typedef struct packed {
        logic              vld;
        logic [W_USER-1:0] user;
        logic [RES_W-1:0]  result;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    logic [IDX_W-1:0] lead;
    logic             mag_zero;

    ipsxe_floating_point_lzc_v1_0 #(.WIDTH(MAG_W), .IDX_W(IDX_W)) u_lzc (
        .vec   (i_add_out[MAG_W-1:0]),
        .index (lead),
        .zero  (mag_zero)
    );

    always_comb begin
        s1_d         = '0;
        s1_d.vld     = i_valid;
        s1_d.user    = i_user;
        s1_d.sign    = i_add_out[IN_W-1];
        s1_d.exp_sum = i_add_out[IN_W-2 -: EXP_WIDTH+1];
        s1_d.mag     = i_add_out[MAG_W-1:0];
        s1_d.lead    = lead;
        s1_d.zero    = mag_zero;
    end

    ipsxe_floating_point_register_v1_0 #(.WIDTH($bits(s1_t)), .ENABLE(LATENCY_CONFIG >= 1)) u_reg_s1 (
        .clk(i_clk), .rst_n(i_rst_n), .ce(i_aclken), .d(s1_d), .q(s1_q)
    );

    // Leading one moves to the top bit (hidden-bit position of the aligned word).
    always_comb begin
        s2_d         = '0;
        s2_d.vld     = s1_q.vld;
        s2_d.user    = s1_q.user;
        s2_d.sign    = s1_q.sign;
        s2_d.zero    = s1_q.zero;
        s2_d.aligned = s1_q.mag << (IDX_W'(MAG_W - 1) - s1_q.lead);
        s2_d.exp     = IEXP_W'(s1_q.exp_sum) + IEXP_W'(s1_q.lead)
                     - IEXP_W'(EXP_BIAS + 2 * MAN_WIDTH);
    end

    ipsxe_floating_point_register_v1_0 #(.WIDTH($bits(s2_t)), .ENABLE(LATENCY_CONFIG >= 2)) u_reg_s2 (
        .clk(i_clk), .rst_n(i_rst_n), .ce(i_aclken), .d(s2_d), .q(s2_q)
    );

    logic [MAN_WIDTH:0]         kept;
    logic                       guard;
    logic                       sticky;
    logic                       inc;
    logic                       carry;
    logic [MAN_WIDTH-1:0]       frac;
    logic signed [IEXP_W-1:0]   exp_rnd;

    always_comb begin
        kept    = s2_q.aligned[MAG_W-1 -: MAN_WIDTH+1];
        guard   = s2_q.aligned[MAN_WIDTH+1];
        sticky  = |s2_q.aligned[MAN_WIDTH:0];
        inc     = guard & (sticky | kept[0]);
        // All-ones significand rolls over: fraction wraps to zero, exponent bumps.
        carry   = inc & (&kept);
        frac    = kept[MAN_WIDTH-1:0] + MAN_WIDTH'(inc);
        exp_rnd = $signed(s2_q.exp) + IEXP_W'(carry);

        s3_d      = '0;
        s3_d.vld  = s2_q.vld;
        s3_d.user = s2_q.user;
        if (s2_q.zero) begin
            s3_d.result = '0;
        end else if (exp_rnd >= EXP_INF) begin
            s3_d.result = {s2_q.sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
        end else if (exp_rnd <= EXP_ZERO) begin
            s3_d.result = {s2_q.sign, {(RES_W-1){1'b0}}};
        end else begin
            s3_d.result = {s2_q.sign, exp_rnd[EXP_WIDTH-1:0], frac};
        end
    end

    ipsxe_floating_point_register_v1_0 #(.WIDTH($bits(s3_t)), .ENABLE(LATENCY_CONFIG >= 3)) u_reg_s3 (
        .clk(i_clk), .rst_n(i_rst_n), .ce(i_aclken), .d(s3_d), .q(s3_q)
    );

    assign o_valid  = s3_q.vld;
    assign o_result = s3_q.result;
    assign o_user   = s3_q.user;

endmodule

// File: tb/tb_ipsxe_floating_point_fma_normalizer_v1_0.sv
// Bench for the FMA normaliser at single precision, LATENCY_CONFIG=3: directed corner
// cases, clock-enable stalls, random traffic and mid-stream reset against a numeric model.
module tb_ipsxe_floating_point_fma_normalizer_v1_0;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_aclken;
    logic        i_valid;
    logic [58:0] i_add_out;
    logic [0:0]  i_user;
    logic        o_valid;
    logic [31:0] o_result;
    logic [0:0]  o_user;

    ipsxe_floating_point_fma_normalizer_v1_0 #(
        .EXP_WIDTH(8), .MAN_WIDTH(23), .LATENCY_CONFIG(3), .W_USER(1)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_aclken  (i_aclken),
        .i_valid   (i_valid),
        .i_add_out (i_add_out),
        .i_user    (i_user),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_user    (o_user)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Value = mag * 2^-46 * 2^(exp_sum-254); rounded to 24 significant bits, nearest-even.
    function automatic logic [31:0] ref_norm(input logic s, input int e, input longint unsigned m);
        int                lead;
        int                sh;
        int                ex;
        longint unsigned   kept;
        longint unsigned   rem;
        longint unsigned   half;
        logic [31:0]       r;
        if (m == 0) return 32'h0;
        lead = 48;
        while (m[lead] == 1'b0) lead--;
        sh = lead - 23;
        if (sh > 0) begin
            kept = m >> sh;
            rem  = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        end else begin
            kept = m << (-sh);
        end
        ex = e - 127 + lead - 46;
        if (kept == (64'd1 << 24)) begin
            kept = kept >> 1;
            ex   = ex + 1;
        end
        if (ex >= 255)     r = {s, 8'hFF, 23'h0};
        else if (ex <= 0)  r = {s, 31'h0};
        else               r = {s, ex[7:0], kept[22:0]};
        return r;
    endfunction

    // Expected contents of the three-deep pipe, advanced only on enabled edges.
    logic        pv[3];
    logic [31:0] pr[3];
    logic        pu[3];

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; pr[i] = 32'h0; pu[i] = 1'b0;
        end
    endtask

    task automatic cycle(input logic v, input logic s, input logic [8:0] e, input logic [48:0] m,
                         input logic u, input logic ce, input logic use_given, input logic [31:0] given);
        i_valid   = v;
        i_aclken  = ce;
        i_add_out = {s, e, m};
        i_user    = u;
        @(posedge i_clk);
        if (ce) begin
            pv[2] = pv[1]; pr[2] = pr[1]; pu[2] = pu[1];
            pv[1] = pv[0]; pr[1] = pr[0]; pu[1] = pu[0];
            pv[0] = v;
            pr[0] = use_given ? given : ref_norm(s, int'(e), longint'(m));
            pu[0] = u;
        end
        #1;
        chk("valid", {63'h0, o_valid}, {63'h0, pv[2]});
        if (pv[2]) begin
            chk("result", {32'h0, o_result}, {32'h0, pr[2]});
            chk("user", {63'h0, o_user}, {63'h0, pu[2]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'd0, 49'd0, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    typedef struct {
        logic        s;
        logic [8:0]  e;
        logic [48:0] m;
        logic [31:0] r;
    } vec_t;

    vec_t dir[10];

    initial begin
        logic [48:0] b46;
        logic [48:0] m;
        int          k;
        b46 = 49'd1 << 46;
        dir[0] = '{1'b0, 9'd254, b46,                                    32'h3F800000};
        dir[1] = '{1'b0, 9'd254, 49'd1 << 47,                            32'h40000000};
        dir[2] = '{1'b0, 9'd254, b46 | (49'd1 << 22),                    32'h3F800000};
        dir[3] = '{1'b0, 9'd254, b46 | (49'd1 << 23) | (49'd1 << 22),    32'h3F800002};
        dir[4] = '{1'b0, 9'd254, b46 | (49'd1 << 22) | 49'd1,            32'h3F800001};
        dir[5] = '{1'b0, 9'd382, b46,                                    32'h7F800000};
        dir[6] = '{1'b1, 9'd382, b46,                                    32'hFF800000};
        dir[7] = '{1'b0, 9'd381, {49{1'b1}},                             32'h7F800000};
        dir[8] = '{1'b1, 9'd127, b46,                                    32'h80000000};
        dir[9] = '{1'b1, 9'd200, 49'd0,                                  32'h00000000};

        clear_model();
        i_rst_n   = 1'b0;
        i_aclken  = 1'b1;
        i_valid   = 1'b0;
        i_add_out = '0;
        i_user    = '0;
        #1;
        chk("rst_valid", {63'h0, o_valid}, 64'h0);
        chk("rst_result", {32'h0, o_result}, 64'h0);
        chk("rst_user", {63'h0, o_user}, 64'h0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Directed corners back-to-back, checked against literal IEEE encodings.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, dir[i].s, dir[i].e, dir[i].m, 1'(i), 1'b1, 1'b1, dir[i].r);
        idle(4);

        // Five words with a two-cycle enable stall in the middle.
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 1'b0, 9'd254 + 9'(i), b46 | 49'(i), 1'(i), 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 1'b1, 9'd300, b46, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 2; i < 5; i++)
            cycle(1'b1, 1'b0, 9'd254 + 9'(i), b46 | 49'(i), 1'(i), 1'b1, 1'b0, 32'h0);
        idle(4);

        // Random traffic with random enable and valid gaps.
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 49);
            m = {17'($urandom), $urandom};
            if (k == 0) m = '0;
            else if (k < 49) m = (m & ((49'd1 << k) - 1)) | (49'd1 << (k - 1));
            if ($urandom_range(0, 3) == 0 && k > 26)
                m = (m & ~((49'd1 << (k - 25)) - 1)) | (49'd1 << (k - 26));
            cycle($urandom_range(0, 9) < 7, 1'($urandom), 9'($urandom_range(60, 420)), m,
                  1'($urandom), $urandom_range(0, 9) < 8, 1'b0, 32'h0);
        end
        idle(4);

        // Reset with three words in flight: everything in the pipe must vanish.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 9'd254, b46, 1'b1, 1'b1, 1'b0, 32'h0);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("mid_rst_valid", {63'h0, o_valid}, 64'h0);
        chk("mid_rst_result", {32'h0, o_result}, 64'h0);
        chk("mid_rst_user", {63'h0, o_user}, 64'h0);
        clear_model();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        idle(5);
        cycle(1'b1, 1'b0, 9'd255, b46, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 9'd250, 49'd1 << 40, 1'b1, 1'b1, 1'b0, 32'h0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
